// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared definitions for the 4-requester round-robin arbiter:
//               FSM state encoding, requester count, default hold limit and
//               the round-robin search helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NUM_REQ          = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

    // Arbiter FSM: IDLE means no grant outstanding, GRANT means one is live.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Result of a round-robin search.
    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // Return the first requester with req set, starting one past ptr and
    // wrapping. ptr itself is examined last, so the previous winner has
    // lowest priority. Iterating from the farthest offset down lets the
    // nearest match overwrite the others.
    function automatic rr_pick_t rr_search(
        input logic [NUM_REQ-1:0] req,
        input logic [1:0]         ptr
    );
        rr_pick_t   pick;
        logic [1:0] cand;
        pick.found = 1'b0;
        pick.idx   = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_2x4.sv
`default_nettype none
// ============================================================================
// Module      : decoder_2x4
// Description : 2-to-4 line decoder. {a,b} selects one of w,x,y,z
//               (w = 0, x = 1, y = 2, z = 3).
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_2x4 (
    input  logic a,
    input  logic b,
    output logic w,
    output logic x,
    output logic y,
    output logic z
);

    // Pure combinational decode of the 2-bit select.
    always_comb begin
        w = ~a & ~b;
        x = ~a &  b;
        y =  a & ~b;
        z =  a &  b;
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : 4-requester round-robin arbiter with grant hold. The grant
//               index is registered; the one-hot grant is its decode gated by
//               gnt_valid. The granted index doubles as the round-robin
//               pointer, so the last winner is lowest priority next time.
//               Optional macro ARB_TIMEOUT_EN adds a hold counter that forces
//               re-arbitration after MAX_HOLD cycles when others are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_idx,
    output logic               gnt_valid
);

    // Reject illegal configurations at elaboration.
    if (MAX_HOLD < 2 || MAX_HOLD > 15 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_param_check
        $error("rr_arbiter_4: MAX_HOLD must be 2..15 and fit in HOLD_W bits");
    end

    arb_state_e state_q, state_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    rr_pick_t   w_pick;
    logic       w_new_grant;
    logic       w_timeout;
    logic [3:0] w_dec;

    // Candidate winner searched from one past the current pointer.
    always_comb begin
        w_pick = rr_search(req, gnt_idx_q);
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              w_others;

    // Another requester is pending besides the current holder.
    always_comb begin
        w_others  = |(req & ~(4'b0001 << gnt_idx_q));
        w_timeout = (state_q == GRANT) && req[gnt_idx_q] &&
                    (hold_cnt_q == C_HOLD_MAX) && w_others;
    end

    // Hold counter: cleared on each new grant, counts while holding, saturates.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (w_new_grant || state_q == IDLE) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != C_HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    // Without the timeout a holder keeps the grant while its req stays high.
    always_comb begin
        w_timeout = 1'b0;
    end
`endif

    // Next-state: arbitrate from IDLE, hold or hand over back-to-back in GRANT.
    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        w_new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_pick.found) begin
                    state_d     = GRANT;
                    gnt_idx_d   = w_pick.idx;
                    w_new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_q] || w_timeout) begin
                    if (w_pick.found) begin
                        gnt_idx_d   = w_pick.idx;
                        w_new_grant = 1'b1;
                    end else begin
                        // Nobody left: release, but keep the index as pointer.
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pointer registers; index 3 makes requester 0 first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_idx_q <= 2'd3;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    decoder_2x4 u_dec (
        .a (gnt_idx_q[1]),
        .b (gnt_idx_q[0]),
        .w (w_dec[0]),
        .x (w_dec[1]),
        .y (w_dec[2]),
        .z (w_dec[3])
    );

    // Outputs come straight from the state/pointer flops and their decode.
    always_comb begin
        gnt_valid = (state_q == GRANT);
        gnt_idx   = gnt_idx_q;
        gnt       = w_dec & {NUM_REQ{gnt_valid}};
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Self-checking bench for rr_arbiter_4: directed vector table,
//               hand-written hold/timeout sequences, and randomized requests
//               checked against a behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_checks;
    int n_pass;

    // Reference model state
    int m_idx;
    bit m_valid;
    int m_hold;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter_4 #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: one clock edge with the given rst/req.
    task automatic model_edge(input logic r_rst, input logic [3:0] r);
        int  others;
        bit  tmo;
        bit  found;
        int  pick;
        if (r_rst) begin
            m_idx   = 3;
            m_valid = 0;
            m_hold  = 0;
            return;
        end
        others = 0;
        for (int k = 0; k < 4; k++) begin
            if (k != m_idx && r[k]) others++;
        end
        tmo = 0;
`ifdef ARB_TIMEOUT_EN
        tmo = m_valid && r[m_idx] && (m_hold == MAX_HOLD - 1) && (others > 0);
`endif
        if (m_valid && r[m_idx] && !tmo) begin
            if (m_hold < MAX_HOLD - 1) m_hold++;
        end else begin
            found = 0;
            pick  = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && r[(m_idx + k) % 4]) begin
                    found = 1;
                    pick  = (m_idx + k) % 4;
                end
            end
            m_hold = 0;
            if (found) begin
                m_idx   = pick;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    // Apply rst/req, take one edge, settle past the edge, advance the model.
    task automatic tick(input logic r_rst, input logic [3:0] r);
        rst = r_rst;
        req = r;
        @(posedge clk);
        #1;
        model_edge(r_rst, r);
    endtask

    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_valid) g[m_idx] = 1'b1;
        return g;
    endfunction

    int   wait_g[4];
    int   wait_c[4];
    int   max_wait_g;
    int   max_wait_c;
    logic prev_valid;
    logic [1:0] prev_idx;
    logic [3:0] r_req;
    logic [3:0] exp_g;
    bit   new_grant;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        m_idx    = 3;
        m_valid  = 0;
        m_hold   = 0;

        // ---------------- directed vector table ----------------
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1});
        tbl.push_back('{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1});
        tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1});

        tick(1'b1, 4'b0000);
        for (int v = 0; v < tbl.size(); v++) begin
            tick(tbl[v].rst, tbl[v].req);
            check($sformatf("tbl%0d_gnt", v),       32'(gnt),       32'(tbl[v].gnt));
            check($sformatf("tbl%0d_gnt_idx", v),   32'(gnt_idx),   32'(tbl[v].idx));
            check($sformatf("tbl%0d_gnt_valid", v), 32'(gnt_valid), 32'(tbl[v].valid));
        end

        // ---------------- two requesters held continuously ----------------
        tick(1'b1, 4'b0000);
        for (int c = 0; c < 32; c++) begin
            tick(1'b0, 4'b0011);
`ifdef ARB_TIMEOUT_EN
            exp_g = (((c / MAX_HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
            exp_g = 4'b0001;
`endif
            check($sformatf("hold2_c%0d", c), 32'(gnt), 32'(exp_g));
        end

        // ---------------- single requester never times out ----------------
        for (int c = 0; c < 24; c++) begin
            tick(1'b0, 4'b0001);
            check($sformatf("hold1_c%0d", c), 32'(gnt), 32'(4'b0001));
        end

        // ---------------- randomized against the model ----------------
        tick(1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            wait_g[i] = 0;
            wait_c[i] = 0;
        end
        max_wait_g = 0;
        max_wait_c = 0;
        r_req      = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            prev_valid = gnt_valid;
            prev_idx   = gnt_idx;
            r_req      = r_req ^ (4'($urandom) & 4'($urandom));
            tick(1'b0, r_req);
            check("rand_gnt",       32'(gnt),       32'(model_gnt()));
            check("rand_gnt_valid", 32'(gnt_valid), 32'(m_valid));
            check("rand_gnt_idx",   32'(gnt_idx),   32'(m_idx));
            check("rand_onehot0",   32'($onehot0(gnt)), 32'(1));
            check("rand_valid_or",  32'(gnt_valid),     32'(|gnt));
            check("rand_gnt_has_req", 32'(gnt & ~r_req), 32'(0));
            new_grant = gnt_valid && (!prev_valid || gnt_idx != prev_idx);
            for (int i = 0; i < 4; i++) begin
                if (!r_req[i] || (gnt_valid && gnt_idx == 2'(i))) begin
                    wait_g[i] = 0;
                    wait_c[i] = 0;
                end else begin
                    wait_c[i]++;
                    if (new_grant) wait_g[i]++;
                    if (wait_g[i] > max_wait_g) max_wait_g = wait_g[i];
                    if (wait_c[i] > max_wait_c) max_wait_c = wait_c[i];
                end
            end
        end
        check("starve_grants", 32'(max_wait_g <= 3), 32'(1));
`ifdef ARB_TIMEOUT_EN
        check("starve_cycles", 32'(max_wait_c <= 3 * MAX_HOLD), 32'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- 4-requester round-robin arbiter with grant hold.
- Shares one downstream resource, e.g. a bus or a decoded select line, among four requesters.
- Registered arbitration picks the grant index; the one-hot grant comes from decoding that index.
- Sits between requester logic and the shared resource's select inputs.

Parameters:
- MAX_HOLD, 8: cycles one requester may hold the grant while others wait. Used only with ARB_TIMEOUT_EN. Legal range 2..15.
- HOLD_W, 4: hold counter width. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i. Held high for as long as the grant is wanted.
- gnt  output  4  one-hot grant; all zero when no grant is active.
- gnt_idx  output  2  index of the current or last granted requester. Meaningful only while gnt_valid=1.
- gnt_valid  output  1  high while a grant is active.

Behaviour:
- Clock/reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset values: gnt=4'b0000, gnt_valid=0, gnt_idx=2'd3, hold counter=0, state=IDLE. Reset value 3 makes requester 0 highest priority on the first arbitration.
- State IDLE:
  - If req!=0 at edge N, grant the first requester with req set, searching from (gnt_idx+1) mod 4 upward with wrap.
  - gnt_idx, gnt_valid=1 and gnt are visible after edge N. Latency is 1 cycle; go to GRANT.
  - If req==0, stay in IDLE with gnt=0.
- State GRANT:
  - While req[gnt_idx]=1, hold the grant unchanged.
  - When req[gnt_idx]=0 and other bits are set: re-arbitrate back-to-back, searching from gnt_idx+1. The new grant is visible after the same edge, with no idle cycle. Stay in GRANT.
  - When req[gnt_idx]=0 and req==0: go to IDLE. gnt=0 and gnt_valid=0 after that edge. gnt_idx keeps its value as the round-robin pointer.
- The pointer is gnt_idx itself. The granted requester becomes lowest priority at the next arbitration.
- gnt = one-hot decode of gnt_idx, ANDed with gnt_valid. Never more than one bit set.
- A requester that drops and re-raises req in the same cycle that another requester is pending loses its turn.
- A requester with req low can never be granted, including during re-arbitration.
- Reset asserted mid-grant: all outputs take their reset values after that edge, regardless of req.
- Hold counter:
  - Cleared on every new grant.
  - Increments each cycle in GRANT.
  - Saturates at MAX_HOLD-1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - If counter==MAX_HOLD-1, req[gnt_idx]=1, and some other req bit is set, force re-arbitration at that edge.
  - Search starts from gnt_idx+1, so the current holder is excluded unless it is the only requester.
  - The counter clears on the new grant.
  - If no other requester is pending, the grant is held and the counter stays saturated.
- Undefined:
  - The counter and compare logic are omitted.
  - A grant is held indefinitely while req[gnt_idx]=1.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding: IDLE=1'b0, GRANT=1'b1;
  - NUM_REQ=4;
  - default MAX_HOLD.
- Sub-module: the existing decoder_2x4 generates gnt. Connections:
  - a=gnt_idx[1], b=gnt_idx[0];
  - w, x, y, z map to grant bits 0, 1, 2, 3;
  - each output is ANDed with gnt_valid.
- Round-robin search function lives in arb_pkg.

Test Plan:
- Reset, then req=4'b1111 held → gnt=4'b0001, gnt_idx=0 one cycle after first sample.
  - Without ARB_TIMEOUT_EN, drop req[0] → next edge gnt=4'b0010.
  - Continued release cycling yields 0100, then 1000, then 0001.
- req=4'b0100 for 3 cycles then 4'b0000 → gnt=0100 for 3 cycles, then gnt=0000 and gnt_valid=0 on the next edge, gnt_idx stays 2.
  - Then req=4'b0101 → gnt=0001, because search starts at index 3 and wraps to 0.
- In GRANT with gnt_idx=1, drop req[1] while raising req[3] in the same cycle → gnt goes 0010 to 1000 in one edge, no gap.
- With ARB_TIMEOUT_EN and MAX_HOLD=8, req=4'b0011 held → gnt=0001 for exactly 8 cycles, then 0010 for 8 cycles, alternating.
  - With req=4'b0001 alone, gnt=0001 held for 20+ cycles.
- Assert rst for 1 cycle while gnt=0100 and req=4'b1111 → after the edge, gnt=0, gnt_valid=0, gnt_idx=3.
  - On the next edge, gnt=0001.
- Random req for 10k cycles, checked every cycle:
  - $onehot0(gnt);
  - gnt_valid == |gnt;
  - a granted bit always has its req set;
  - no pending requester waits more than 3 grants, or 3*MAX_HOLD cycles with the timeout enabled.
